// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking,
// stall, flush, a combinational tap mux and an occupancy count.
module dff_pipe #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int             SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic [SW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] tap_q_s;
    logic             tap_valid_s;

    // Stage data, valid flags and occupancy; priority rst > flush > en > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            // Data is deliberately kept; only the valid view is cleared.
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_r[i] <= stage_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
            stage_r[0] <= d;
            valid_r[0] <= d_valid;
            count_r    <= count_r + CW'(d_valid) - CW'(valid_r[DEPTH-1]);
        end else begin
            count_r <= count_r;
        end
    end

    // Tap mux: out-of-range selects fall back to RESET_VAL / invalid.
    always_comb begin
        tap_q_s     = RESET_VAL;
        tap_valid_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((DEPTH == 1) || (tap_sel == SW'(i))) begin
                tap_q_s     = stage_r[i];
                tap_valid_s = valid_r[i];
            end else begin
                tap_q_s     = tap_q_s;
                tap_valid_s = tap_valid_s;
            end
        end
    end

    assign q         = stage_r[DEPTH-1];
    assign q_valid   = valid_r[DEPTH-1];
    assign count     = count_r;
    assign tap_q     = tap_q_s;
    assign tap_valid = tap_valid_s;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe: DEPTH=4 main instance plus
// DEPTH=3 (RESET_VAL=0x5A) and DEPTH=1 instances sharing the stimulus.
module tb_dff_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_valid;

    logic [1:0] tap_sel4;
    logic [7:0] q4, tq4;
    logic       qv4, tv4;
    logic [2:0] cnt4;

    logic [1:0] tap_sel3;
    logic [7:0] q3, tq3;
    logic       qv3, tv3;
    logic [1:0] cnt3;

    logic [0:0] tap_sel1;
    logic [7:0] q1, tq1;
    logic       qv1, tv1;
    logic [0:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q4), .q_valid(qv4), .tap_sel(tap_sel4), .tap_q(tq4),
        .tap_valid(tv4), .count(cnt4)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q3), .q_valid(qv3), .tap_sel(tap_sel3), .tap_q(tq3),
        .tap_valid(tv3), .count(cnt3)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .tap_sel(tap_sel1), .tap_q(tq1),
        .tap_valid(tv1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vals2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] cnt2  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       dv5   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] cnt5  [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic       qv5   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        tap_sel4 = 2'd0; tap_sel3 = 2'd0; tap_sel1 = 1'b0;

        // 1: reset state
        tick();
        rst = 1'b0;
        check_eq("rst_q", 32'(q4), 32'h0);
        check_eq("rst_qv", 32'(qv4), 32'h0);
        check_eq("rst_cnt", 32'(cnt4), 32'h0);
        for (int s = 0; s < 4; s++) begin
            tap_sel4 = 2'(s);
            #1;
            check_eq($sformatf("rst_tv%0d", s), 32'(tv4), 32'h0);
        end

        // 2: streaming with en held high, latency DEPTH
        en = 1'b1; d_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = vals2[k];
            tick();
            check_eq($sformatf("str_cnt%0d", k), 32'(cnt2[k]), 32'(cnt4));
            check_eq($sformatf("str_qv%0d", k), 32'(qv4), (k >= 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("str_q%0d", k), 32'(q4), (k >= 3) ? 32'(vals2[k-3]) : 32'h0);
        end

        // 3: stall holds everything
        rst = 1'b1; tick(); rst = 1'b0;
        d = 8'hA1; tick();
        d = 8'hA2; tick();
        d = 8'hA3; tick();
        en = 1'b0; d = 8'hEE; tap_sel4 = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("stall_q%0d", k), 32'(q4), 32'h0);
            check_eq($sformatf("stall_cnt%0d", k), 32'(cnt4), 32'd3);
            check_eq($sformatf("stall_tap%0d", k), 32'(tq4), 32'hA2);
        end
        en = 1'b1; d = 8'hA4;
        tick();
        check_eq("resume_q", 32'(q4), 32'hA1);
        check_eq("resume_qv", 32'(qv4), 32'h1);
        check_eq("resume_cnt", 32'(cnt4), 32'd4);

        // 4: flush with en drops d, keeps data
        flush = 1'b1; d = 8'hFF; tap_sel4 = 2'd0;
        tick();
        flush = 1'b0;
        check_eq("flush_cnt", 32'(cnt4), 32'h0);
        check_eq("flush_qv", 32'(qv4), 32'h0);
        check_eq("flush_q", 32'(q4), 32'hA1);
        check_eq("flush_tap0", 32'(tq4), 32'hA4);
        check_eq("flush_tv0", 32'(tv4), 32'h0);
        d = 8'h66;
        tick();
        check_eq("post_tap0", 32'(tq4), 32'h66);
        check_eq("post_tv0", 32'(tv4), 32'h1);
        check_eq("post_cnt", 32'(cnt4), 32'd1);
        check_eq("post_q", 32'(q4), 32'hA2);

        // 5: alternating valids, then reset mid-stream
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d = 8'(k + 1); d_valid = dv5[k];
            tick();
            check_eq($sformatf("alt_cnt%0d", k), 32'(cnt4), 32'(cnt5[k]));
            check_eq($sformatf("alt_qv%0d", k), 32'(qv4), 32'(qv5[k]));
        end
        d = 8'h77; d_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_cnt", 32'(cnt4), 32'h0);
        check_eq("mid_rst_qv", 32'(qv4), 32'h0);
        check_eq("mid_rst_q", 32'(q4), 32'h0);
        check_eq("mid_rst_tap0", 32'(tq4), 32'h0);

        // 6: DEPTH=3 out-of-range tap and DEPTH=1 single register
        en = 1'b0; tap_sel3 = 2'd3;
        #1;
        check_eq("d3_tap3_q", 32'(tq3), 32'h5A);
        check_eq("d3_tap3_v", 32'(tv3), 32'h0);
        check_eq("d3_rst_q", 32'(q3), 32'h5A);
        check_eq("d1_rst_qv", 32'(qv1), 32'h0);
        en = 1'b1; d = 8'h3C; d_valid = 1'b1;
        tick();
        check_eq("d1_q", 32'(q1), 32'h3C);
        check_eq("d1_qv", 32'(qv1), 32'h1);
        check_eq("d1_cnt", 32'(cnt1), 32'h1);
        tap_sel1 = 1'b1;
        #1;
        check_eq("d1_tap", 32'(tq1), 32'h3C);
        check_eq("d3_tap3_busy", 32'(tq3), 32'h5A);
        check_eq("d3_tap3_busy_v", 32'(tv3), 32'h0);
        tap_sel3 = 2'd0;
        #1;
        check_eq("d3_tap0", 32'(tq3), 32'h3C);
        check_eq("d3_tv0", 32'(tv3), 32'h1);
        en = 1'b0; d_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
